// File: rtl/ysyx_23060096_lsu.sv
// Multi-cycle load/store unit: accepts one memory op, drives a word-addressed bus,
// returns lane-formatted load data with misalign/illegal-op/timeout error reporting.
`timescale 1ns/1ps
module ysyx_23060096_lsu #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic [2:0]  mem_op,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);
  localparam bit          TimeoutEn  = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic        wr_q, err_q, err_d, cap_en;
  logic [2:0]  op_q;
  logic        req_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic        is_req;

  // Request screening, evaluated on the raw inputs at the accept edge.
  always_comb begin
    req_bad = 1'b0;
    case (mem_op)
      3'b000, 3'b100: req_bad = mem_wr & mem_op[2];
      3'b001, 3'b101: req_bad = (mem_wr & mem_op[2]) | addr[0];
      3'b010:         req_bad = (addr[1:0] != 2'b00);
      default:        req_bad = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = mem_resp_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_resp_rdata[7:0];
      2'b01:   ld_byte = mem_resp_rdata[15:8];
      2'b10:   ld_byte = mem_resp_rdata[23:16];
      default: ld_byte = mem_resp_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    case (op_q[1:0])
      2'b00:   ld_data = {{24{~op_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~op_q[2] & ld_half[15]}}, ld_half};
      default: ld_data = mem_resp_rdata;
    endcase
  end

  always_comb begin
    case (op_q[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {addr_q[1], 1'b0};
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cap_en = 1'b1;
          if (req_bad) begin
            state_d = StDone;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (mem_resp_valid) begin
          state_d = StDone;
          err_d   = 1'b0;
          rdata_d = wr_q ? 32'h0 : ld_data;
        end else if (TimeoutEn && cnt_q == TimeoutCnt) begin
          state_d = StDone;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      op_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (cap_en) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= mem_wr;
        op_q    <= mem_op;
      end
    end
  end

  // Bus outputs are forced to zero outside REQ so reset and idle look identical.
  assign is_req        = (state_q == StReq);
  assign req_ready     = (state_q == StIdle);
  assign resp_valid    = (state_q == StDone);
  assign rdata         = rdata_q;
  assign err           = err_q;
  assign mem_req_valid = is_req;
  assign mem_req_addr  = is_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_req_wen   = is_req & wr_q;
  assign mem_req_wdata = (is_req & wr_q) ? st_data : 32'h0;
  assign mem_req_wstrb = (is_req & wr_q) ? st_strb : 4'b0000;

endmodule

// File: doc/ysyx_23060096_lsu.md
# ysyx_23060096_lsu

Multi-cycle load/store unit that sits directly downstream of the core's execute stage. It accepts one memory operation per request: the ALU result as the address, the rs2 value as store data, and the MemWr/MemOP controls. It drives a word-addressed data-memory bus with valid/ready request and valid response handshakes, and returns byte-lane-formatted, sign- or zero-extended load data to register write-back. Misaligned accesses, illegal MemOP codes and response timeouts are reported through `err`.

## Interface
- `TIMEOUT`, default 256: maximum number of cycles spent in WAIT before abort; 0 disables the timeout; legal range 0..65535.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: an operation is presented.
- `req_ready` out 1: the LSU can accept an operation.
- `addr` in 32: byte address (ALU out).
- `wdata` in 32: store data (rs2), least-significant-byte aligned.
- `mem_wr` in 1: 1 = store, 0 = load.
- `mem_op` in 3: width code. 000 = byte, 001 = half, 010 = word, 100 = byte unsigned, 101 = half unsigned.
- `resp_valid` out 1: one-cycle pulse when the operation completes.
- `rdata` out 32: formatted load data; 0 for stores and errors.
- `err` out 1: qualified by `resp_valid`. 1 = misaligned, illegal op, or timeout.
- `mem_req_valid` out 1: bus request valid.
- `mem_req_ready` in 1: bus accepts the request.
- `mem_req_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_req_wen` out 1: write request.
- `mem_req_wdata` out 32: lane-replicated store data.
- `mem_req_wstrb` out 4: byte enables; 0000 for reads.
- `mem_resp_valid` in 1: bus response valid, one cycle, for both reads and writes.
- `mem_resp_rdata` in 32: read word.

## Operation
- FSM states and transitions:
  - IDLE: `req_ready`=1. A request is accepted when `req_valid&req_ready`, and the LSU captures `addr`, `wdata`, `mem_wr`, `mem_op`.
  - IDLE → DONE with `err`=1, no bus access, if any of these holds:
    - `mem_op` is not in {000,001,010,100,101};
    - `mem_wr`=1 with `mem_op` 100 or 101;
    - a half access has `addr[0]`=1;
    - a word access has `addr[1:0]`≠00.
  - IDLE → REQ otherwise.
  - REQ: `mem_req_valid`=1, with all `mem_req_*` outputs held stable until `mem_req_ready`. On `mem_req_valid&mem_req_ready` go to WAIT and clear the timeout counter.
  - WAIT: on `mem_resp_valid` go to DONE with `err`=0. A load latches `mem_resp_rdata`. If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`, go to DONE with `err`=1. Otherwise the counter increments; it is 16 bits wide and saturates.
  - DONE: `resp_valid`=1 for exactly one cycle, `req_ready`=0, then return to IDLE.
- Store formatting:
  - byte: `wstrb`=0001<<`addr[1:0]`, `wdata`={4{`wdata[7:0]`}};
  - half: `wstrb`=0011<<{`addr[1]`,0}, `wdata`={2{`wdata[15:0]`}};
  - word: `wstrb`=1111.
- Load formatting:
  - select byte lane `addr[1:0]` or half lane `addr[1]`;
  - codes 000 and 001 sign-extend from bit 7 or bit 15;
  - codes 100 and 101 zero-extend;
  - word passes through unchanged.
- `mem_resp_valid` is ignored in IDLE, REQ and DONE. A response arriving after a timeout is a system error and is not tracked.
- `mem_resp_valid` in the same cycle as the `mem_req_ready` handshake is not sampled. The bus returns a response at least one cycle after the handshake.

## Timing
- Reset values and behaviour:
  - State resets to IDLE and the counter to 0.
  - `req_ready`=1 during reset; `resp_valid`, `err`, `mem_req_valid`, `mem_req_wen` = 0; `rdata`, `mem_req_addr`, `mem_req_wdata` = 0; `mem_req_wstrb`=0000.
  - Reset asserted mid-operation aborts immediately: `mem_req_valid` drops asynchronously and no `resp_valid` is produced.
- All outputs are registered or decoded from state plus captured registers. There is no combinational path from any input to any output.
- Latency is counted from the accept edge (cycle 0):
  - REQ is at cycle 1.
  - With `mem_req_ready`=1 at cycle 1 and `mem_resp_valid` at cycle 2, `resp_valid` is at cycle 3. This is the minimum for a bus access.
  - Error path: `resp_valid` at cycle 1.
  - Timeout path: `resp_valid` is exactly `TIMEOUT`+1 cycles after entering WAIT.
- Throughput is at most one operation per 4 cycles. `req_ready` is low from cycle 1 through the DONE cycle inclusive.
- `rdata` and `err` are valid only while `resp_valid`=1, and they hold their values until the next DONE.

## Test plan
- LW at `addr` 0x8000_0004, memory returns 0xDEAD_BEEF, `mem_req_ready` and `mem_resp_valid` immediate → `mem_req_addr` 0x8000_0004, `wstrb` 0000, `resp_valid` at cycle 3, `rdata` 0xDEAD_BEEF, `err`=0.
- LB / LBU / LH / LHU at `addr` 0x...03 (byte) and 0x...02 (half), word 0x80FF_7F01 → LB 0xFFFF_FF80, LBU 0x0000_0080, LH 0xFFFF_80FF, LHU 0x0000_80FF.
- SB, `wdata` 0x1234_56AB, `addr` 0x...01 → `wstrb` 0010, `mem_req_wdata` 0xABAB_ABAB, `wen`=1. SH at 0x...02 → `wstrb` 1100, `wdata` 0x56AB_56AB.
- LW at 0x...02, and any access with `mem_op`=011 → no `mem_req_valid`, `resp_valid` at cycle 1 with `err`=1 and `rdata` 0.
- `mem_req_ready` held low 5 cycles, then a response after 7 cycles → `mem_req_*` outputs stable throughout, a single `resp_valid`, `req_ready` stays low until DONE. With `TIMEOUT`=4 and no response → `err`=1 exactly 5 cycles after entering WAIT.
- `rstn` asserted while in WAIT, then a stray `mem_resp_valid` arrives after release → LSU returns to IDLE, no `resp_valid`, and the next LW completes normally.
